// File: rtl/dft_piso_loader.sv
// Parallel-in/serial-out scan loader: buffers 32-bit words, then shifts nbits onto sout with sen high.
// Define DFT_PISO_MSB_FIRST_EN to shift each word bit31 first (default is bit0 first).
module dft_piso_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      din,
  input  logic             din_val,
  output logic             din_rdy,
  input  logic [CNT_W-1:0] nbits,
  input  logic             op,
  output logic             op_ack,
  output logic             scaning,
  output logic             op_commit,
  output logic             sout,
  output logic             sen
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL     = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(DEPTH * 32);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t           state, state_n;
  logic [31:0]      mem [DEPTH];
  logic [AW:0]      fill, rd_ptr, nxt_ptr;
  logic [4:0]       bit_idx, nxt_idx;
  logic [CNT_W-1:0] remaining, nbits_sat;
  logic             wr_en, start, step, clear;
  logic             sout_n, sen_n, op_ack_n, op_commit_n;
  logic             first_bit, next_bit;

  function automatic logic [4:0] bit_sel(input logic [4:0] idx);
`ifdef DFT_PISO_MSB_FIRST_EN
    return 5'd31 - idx;
`else
    return idx;
`endif
  endfunction

  assign din_rdy   = (state == IDLE) && (fill < FULL);
  assign scaning   = (state == SHIFT);
  assign wr_en     = din_val && din_rdy;
  assign nbits_sat = (nbits > MAX_BITS) ? MAX_BITS : nbits;
  assign nxt_idx   = bit_idx + 5'd1;
  assign nxt_ptr   = rd_ptr + {{AW{1'b0}}, (bit_idx == 5'd31)};

  // The first bit must see a word written in the same cycle as the op.
  always_comb begin
    first_bit = 1'b0;
    if (fill != '0)
      first_bit = mem[0][bit_sel(5'd0)];
    else if (wr_en)
      first_bit = din[bit_sel(5'd0)];
    next_bit = 1'b0;
    if (nxt_ptr < fill)
      next_bit = mem[nxt_ptr[AW-1:0]][bit_sel(nxt_idx)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // remaining counts the bits still owed, including the one currently on sout.
  always_comb begin
    state_n     = state;
    sout_n      = 1'b0;
    sen_n       = 1'b0;
    op_ack_n    = 1'b0;
    op_commit_n = 1'b0;
    start       = 1'b0;
    step        = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          op_ack_n = 1'b1;
          if (nbits_sat == '0) begin
            op_commit_n = 1'b1;
            clear       = 1'b1;
          end else begin
            state_n = SHIFT;
            start   = 1'b1;
            sen_n   = 1'b1;
            sout_n  = first_bit;
          end
        end
      end
      SHIFT: begin
        if (remaining == CNT_W'(1)) begin
          state_n     = COMMIT;
          op_commit_n = 1'b1;
          clear       = 1'b1;
        end else begin
          step   = 1'b1;
          sen_n  = 1'b1;
          sout_n = next_bit;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill      <= '0;
      rd_ptr    <= '0;
      bit_idx   <= '0;
      remaining <= '0;
      sout      <= 1'b0;
      sen       <= 1'b0;
      op_ack    <= 1'b0;
      op_commit <= 1'b0;
    end else begin
      sout      <= sout_n;
      sen       <= sen_n;
      op_ack    <= op_ack_n;
      op_commit <= op_commit_n;
      if (clear) begin
        fill      <= '0;
        rd_ptr    <= '0;
        bit_idx   <= '0;
        remaining <= '0;
      end else begin
        if (wr_en) fill <= fill + 1'b1;
        if (start) begin
          rd_ptr    <= '0;
          bit_idx   <= '0;
          remaining <= nbits_sat;
        end
        if (step) begin
          rd_ptr    <= nxt_ptr;
          bit_idx   <= nxt_idx;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: fill gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill[AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_dft_piso_loader.sv
// Self-checking bench for dft_piso_loader: vector table, corner sequences and randomized ops
// checked against a word-queue model of the serial stream.
module tb_dft_piso_loader;
  localparam int DEPTH    = 64;
  localparam int CNT_W    = 14;
  localparam int MAX_BITS = DEPTH * 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      din;
  logic             din_val;
  logic             din_rdy;
  logic [CNT_W-1:0] nbits;
  logic             op;
  logic             op_ack;
  logic             scaning;
  logic             op_commit;
  logic             sout;
  logic             sen;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_words[$];

  always #5 clk = ~clk;

  dft_piso_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_val(din_val), .din_rdy(din_rdy),
    .nbits(nbits), .op(op), .op_ack(op_ack), .scaning(scaning),
    .op_commit(op_commit), .sout(sout), .sen(sen)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int nw;
    int nbits;
    int extra_c;
    int exp_ones;
    int exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Stream bit i comes from word i/32; words never loaded read as zero.
  function automatic logic expBit(input int i);
    int w;
    int b;
    logic [31:0] word;
    w = i / 32;
    if (w >= model_words.size()) return 1'b0;
    word = model_words[w];
    b = i % 32;
`ifdef DFT_PISO_MSB_FIRST_EN
    b = 31 - b;
`endif
    return word[b];
  endfunction

  task automatic applyStimulus(input logic [31:0] w);
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (model_words.size() < DEPTH);
    checkOutput("din_rdy_on_write", din_rdy, exp_rdy);
    din = w;
    din_val = 1'b1;
    if (exp_rdy) model_words.push_back(w);
    @(posedge clk);
    #1 din_val = 1'b0;
  endtask

  task automatic runOp(input int n, input int extra_c, input bit with_write,
                       input logic [31:0] w, output int ones, output int len);
    int eff, ack_cnt, first_ack, commit_c, bad;
    eff = (n > MAX_BITS) ? MAX_BITS : n;
    ones = 0; len = 0; bad = 0; ack_cnt = 0; first_ack = 0; commit_c = 0;
    @(negedge clk);
    op = 1'b1;
    nbits = CNT_W'(n);
    if (with_write) begin
      din = w;
      din_val = 1'b1;
      if (model_words.size() < DEPTH) model_words.push_back(w);
    end
    @(posedge clk);
    #1;
    op = 1'b0;
    din_val = 1'b0;
    for (int c = 1; c <= eff + 20 && commit_c == 0; c++) begin
      @(negedge clk);
      if (op_ack === 1'b1) begin
        ack_cnt++;
        if (first_ack == 0) first_ack = c;
      end
      if (sen === 1'b1) begin
        if (sout !== expBit(len)) bad++;
        if (sout === 1'b1) ones++;
        len++;
      end
      if (op_commit === 1'b1) begin
        commit_c = c;
        checkOutput("commit_sen", sen, 0);
        checkOutput("commit_sout", sout, 0);
        checkOutput("commit_scaning", scaning, 0);
        checkOutput("commit_din_rdy", din_rdy, (eff == 0) ? 1 : 0);
      end else if (c <= eff) begin
        checkOutput("shift_scaning", scaning, 1);
      end
      op = (c == extra_c);
    end
    if (op) begin
      @(posedge clk);
      #1 op = 1'b0;
    end
    checkOutput("ack_count", ack_cnt, 1);
    checkOutput("ack_cycle", first_ack, 1);
    checkOutput("commit_cycle", commit_c, eff + 1);
    checkOutput("stream_len", len, eff);
    checkOutput("stream_bad_bits", bad, 0);
    model_words.delete();
    @(negedge clk);
    checkOutput("idle_din_rdy", din_rdy, 1);
    checkOutput("idle_op_ack", op_ack, 0);
    checkOutput("idle_op_commit", op_commit, 0);
    checkOutput("idle_sen", sen, 0);
  endtask

  initial begin
    int ones, len, nw, n, extra, cnt_commit, cnt_sen;

    vecs[0] = '{32'hA5A5_0003, 32'h8000_0001, 2, 64, 0, 12, 64};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0, 1, 40, 0, 32, 40};
    vecs[2] = '{32'hA5A5_0003, 32'h8000_0001, 2, 16, 5, 2, 16};
    vecs[3] = '{32'h1234_5678, 32'h0, 1, 0, 0, 0, 0};
    vecs[4] = '{32'h0, 32'h0, 0, 8, 0, 0, 8};
    vecs[5] = '{32'h0000_0001, 32'h0000_0001, 2, 33, 0, 2, 33};
    vecs[6] = '{32'h8000_0000, 32'h0, 1, 1, 2, 0, 1};

    reset = 1'b1; din = '0; din_val = 1'b0; nbits = '0; op = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_sout", sout, 0);
    checkOutput("reset_sen", sen, 0);
    checkOutput("reset_op_ack", op_ack, 0);
    checkOutput("reset_op_commit", op_commit, 0);
    checkOutput("reset_din_rdy", din_rdy, 1);
    checkOutput("reset_scaning", scaning, 0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].nw > 0) applyStimulus(vecs[v].w0);
      if (vecs[v].nw > 1) applyStimulus(vecs[v].w1);
      runOp(vecs[v].nbits, vecs[v].extra_c, 1'b0, 32'h0, ones, len);
      checkOutput("vec_ones", ones, vecs[v].exp_ones);
      checkOutput("vec_len", len, vecs[v].exp_len);
    end

    // A write in the same cycle as the op is part of the pattern.
    applyStimulus(32'h0000_0002);
    runOp(40, 0, 1'b1, 32'h0000_0005, ones, len);
    checkOutput("same_cycle_ones", ones, 3);

    // Fill the buffer, push one word too many, then saturate nbits.
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus($urandom);
    runOp(5000, 100, 1'b0, 32'h0, ones, len);
    checkOutput("sat_len", len, MAX_BITS);

    // Reset in the middle of a shift aborts without a commit.
    applyStimulus(32'hDEAD_BEEF);
    applyStimulus(32'hFFFF_FFFF);
    @(negedge clk);
    op = 1'b1;
    nbits = CNT_W'(64);
    @(posedge clk);
    #1 op = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_sout", sout, 0);
    checkOutput("abort_sen", sen, 0);
    checkOutput("abort_scaning", scaning, 0);
    checkOutput("abort_din_rdy", din_rdy, 1);
    @(negedge clk);
    reset = 1'b0;
    model_words.delete();
    cnt_commit = 0;
    cnt_sen = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (op_commit !== 1'b0) cnt_commit++;
      if (sen !== 1'b0) cnt_sen++;
    end
    checkOutput("abort_no_commit", cnt_commit, 0);
    checkOutput("abort_no_sen", cnt_sen, 0);
    applyStimulus(32'h0000_00F0);
    runOp(32, 0, 1'b0, 32'h0, ones, len);
    checkOutput("post_abort_ones", ones, 4);

    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(0, 4);
      for (int i = 0; i < nw; i++) applyStimulus($urandom);
      n = $urandom_range(0, 150);
      extra = (n >= 2) ? $urandom_range(2, n + 1) : 0;
      runOp(n, extra, ($urandom_range(0, 1) == 1), $urandom, ones, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
